// File: rtl/banana_pkg.sv
// Shared types and screen geometry for the banana projectile path.
// Launch height saturates so a spawned banana never starts below the visible area.
package banana_pkg;

    typedef enum logic [2:0] {
        IDLE_ST     = 3'd0,
        ARMED_ST    = 3'd1,
        LAUNCH_ST   = 3'd2,
        FLIGHT_ST   = 3'd3,
        COOLDOWN_ST = 3'd4
    } launcher_state_t;

    localparam int unsigned SCREEN_H      = 479;
    localparam int unsigned OBJECT_H      = 16;
    localparam int unsigned SAFETY_MARGIN = 2;
    localparam int unsigned Y_MAX         = SCREEN_H - SAFETY_MARGIN - OBJECT_H;
    localparam int unsigned COORD_W       = 11;

    typedef logic [COORD_W-1:0] coord_t;

    // 12-bit sum so an offset near the top of the coordinate range cannot wrap
    function automatic coord_t sat_launch_y(input coord_t y,
                                            input logic [11:0] offset,
                                            input logic [11:0] limit);
        logic [11:0] sum_s;
        sum_s = {1'b0, y} + offset;
        if (sum_s > limit) begin
            return limit[COORD_W-1:0];
        end else begin
            return sum_s[COORD_W-1:0];
        end
    endfunction

endpackage

// File: rtl/banana_launcher_frame_counter.sv
// Frame-pulse counter: terminal pulse is combinational so the launcher can
// act on the same frame tick that completes the count.
module frame_counter #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          clear,
    input  logic          count_en,
    input  logic [CW-1:0] terminal,
    output logic          tc
);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_inc_s;

    assign cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    assign tc        = count_en & (cnt_inc_s == terminal);

    // count register: clear wins, terminal count restarts from zero
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (tc) begin
            cnt_r <= '0;
        end else if (count_en) begin
            cnt_r <= cnt_inc_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/banana_launcher.sv
// Launch initiator for the banana mover: ammo budget, cooldown, reload and
// the appear/active handshake, all timed in frames.
module banana_launcher
    import banana_pkg::*;
#(
    parameter int unsigned MAX_SHOTS          = 5,
    parameter int unsigned COOLDOWN_FRAMES    = 15,
    parameter int unsigned ACK_TIMEOUT_FRAMES = 2,
    parameter int unsigned RELOAD_FRAMES      = 60,
    parameter int unsigned Y_OFFSET           = 8,
    parameter int unsigned Y_MAX              = banana_pkg::Y_MAX
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        fire_request,
    input  logic [10:0] thrower_y,
    input  logic        projectile_active,
    output logic        appear,
    output logic [10:0] launch_y,
    output logic [3:0]  shots_left,
    output logic        ready,
    output logic        launch_fail
);

    localparam logic [3:0]  MAX_SHOTS_C  = 4'(MAX_SHOTS);
    localparam logic [11:0] Y_OFFSET_C   = 12'(Y_OFFSET);
    localparam logic [11:0] Y_MAX_C      = 12'(Y_MAX);
    localparam logic [7:0]  ACK_T_C      = 8'(ACK_TIMEOUT_FRAMES);
    localparam logic [7:0]  COOL_T_C     = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0]  RELOAD_T_C   = 8'(RELOAD_FRAMES);
    localparam logic        COOL_ZERO_C  = (COOLDOWN_FRAMES == 0);

    launcher_state_t state_r;
    launcher_state_t state_next_s;
    logic            fire_d_r;
    logic            fire_rise_r;
    logic            appear_r;
    logic            launch_fail_r;
    logic            ready_r;
    coord_t          launch_y_r;
    logic [3:0]      shots_r;
    logic [3:0]      shots_next_s;

    logic launch_s;
    logic ack_s;
    logic timeout_s;
    logic cool_clr_s;
    logic cool_done_s;
    logic ack_en_s;
    logic cool_en_s;
    logic reload_en_s;
    logic reload_clr_s;
    logic ack_tc_s;
    logic cool_tc_s;
    logic reload_tc_s;

    assign ack_en_s     = startOfFrame & enable & (state_r == LAUNCH_ST) & ~projectile_active;
    assign cool_en_s    = startOfFrame & enable & (state_r == COOLDOWN_ST);
    assign reload_clr_s = (shots_r == MAX_SHOTS_C);
    assign reload_en_s  = startOfFrame & ~reload_clr_s;
    assign cool_done_s  = COOL_ZERO_C | cool_tc_s;

    frame_counter #(.CW(8)) u_ack_cnt (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (launch_s),
        .count_en (ack_en_s),
        .terminal (ACK_T_C),
        .tc       (ack_tc_s)
    );

    frame_counter #(.CW(8)) u_cool_cnt (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (cool_clr_s),
        .count_en (cool_en_s),
        .terminal (COOL_T_C),
        .tc       (cool_tc_s)
    );

    frame_counter #(.CW(8)) u_reload_cnt (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (reload_clr_s),
        .count_en (reload_en_s),
        .terminal (RELOAD_T_C),
        .tc       (reload_tc_s)
    );

    // next-state decode; enable low overrides every state
    always_comb begin
        state_next_s = state_r;
        launch_s     = 1'b0;
        ack_s        = 1'b0;
        timeout_s    = 1'b0;
        cool_clr_s   = 1'b0;
        if (!enable) begin
            state_next_s = IDLE_ST;
        end else begin
            case (state_r)
                IDLE_ST: begin
                    state_next_s = ARMED_ST;
                end
                ARMED_ST: begin
                    if (fire_rise_r && (shots_r != 4'd0) && !projectile_active) begin
                        launch_s     = 1'b1;
                        state_next_s = LAUNCH_ST;
                    end else begin
                        state_next_s = ARMED_ST;
                    end
                end
                LAUNCH_ST: begin
                    if (projectile_active) begin
                        ack_s        = 1'b1;
                        state_next_s = FLIGHT_ST;
                    end else if (ack_tc_s) begin
                        timeout_s    = 1'b1;
                        state_next_s = ARMED_ST;
                    end else begin
                        state_next_s = LAUNCH_ST;
                    end
                end
                FLIGHT_ST: begin
                    if (!projectile_active) begin
                        cool_clr_s   = 1'b1;
                        state_next_s = COOLDOWN_ST;
                    end else begin
                        state_next_s = FLIGHT_ST;
                    end
                end
                COOLDOWN_ST: begin
                    if (cool_done_s) begin
                        state_next_s = ARMED_ST;
                    end else begin
                        state_next_s = COOLDOWN_ST;
                    end
                end
                default: begin
                    state_next_s = IDLE_ST;
                end
            endcase
        end
    end

    // ammo: a reload landing on an acknowledged launch cancels out
    always_comb begin
        shots_next_s = shots_r;
        if (ack_s && reload_tc_s) begin
            shots_next_s = shots_r;
        end else if (ack_s && (shots_r != 4'd0)) begin
            shots_next_s = shots_r - 4'd1;
        end else if (reload_tc_s && (shots_r < MAX_SHOTS_C)) begin
            shots_next_s = shots_r + 4'd1;
        end else begin
            shots_next_s = shots_r;
        end
    end

    // state, edge detect and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r       <= IDLE_ST;
            fire_d_r      <= 1'b0;
            fire_rise_r   <= 1'b0;
            appear_r      <= 1'b0;
            launch_fail_r <= 1'b0;
            ready_r       <= 1'b0;
            launch_y_r    <= '0;
            shots_r       <= MAX_SHOTS_C;
        end else begin
            state_r       <= state_next_s;
            fire_d_r      <= fire_request;
            fire_rise_r   <= fire_request & ~fire_d_r;
            appear_r      <= (state_next_s == LAUNCH_ST);
            launch_fail_r <= timeout_s;
            ready_r       <= (state_next_s == ARMED_ST) & (shots_next_s != 4'd0) & ~projectile_active;
            launch_y_r    <= launch_s ? sat_launch_y(thrower_y, Y_OFFSET_C, Y_MAX_C) : launch_y_r;
            shots_r       <= shots_next_s;
        end
    end

    assign appear      = appear_r;
    assign launch_y    = launch_y_r;
    assign shots_left  = shots_r;
    assign ready       = ready_r;
    assign launch_fail = launch_fail_r;

endmodule
